key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan_pkg.sv | 20 ++
 rtl/key_filter.sv | 149 ++++++++++++++
 rtl/key_scan.sv | 33 +++
 tb/tb_key_scan.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared definitions for the key scanner: per-key FSM encoding, key count,
// counter widths and default timing values (50 MHz system clock).
package key_scan_pkg;

  localparam int unsigned KeyNum = 4;
  localparam int unsigned CntW   = 20;
  localparam int unsigned LongW  = 26;

  // 20 ms debounce and 1 s long-press at 50 MHz, both stored as count minus 1
  localparam logic [CntW-1:0]  CntMaxDefault  = 20'd999_999;
  localparam logic [LongW-1:0] LongMaxDefault = 26'd49_999_999;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StPressDb   = 2'd1,
    StDown      = 2'd2,
    StReleaseDb = 2'd3
  } key_fsm_e;

endpackage

// File: rtl/key_filter.sv
// Single-key debouncer: 2-flop synchronizer, press/release debounce FSM,
// registered level and one-cycle press/release/long pulses.
// Long-press detection is compiled in only when KEY_LONG_PRESS_EN is defined.
module key_filter
  import key_scan_pkg::*;
#(
  parameter logic [CntW-1:0]  CNT_MAX  = CntMaxDefault,
  parameter logic [LongW-1:0] LONG_MAX = LongMaxDefault
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  logic [1:0]      sync_q;
  logic            key_low;
  key_fsm_e        st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            state_q, state_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Synchronizer resets to the released level so no press is seen out of reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], key_n_i};
  end

  assign key_low = ~sync_q[1];

  // State register: FSM, debounce counter and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q      <= StIdle;
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state and debounce counter; counter stops at CNT_MAX by leaving the state
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      StIdle: begin
        if (key_low) begin
          st_d  = StPressDb;
          cnt_d = '0;
        end
      end
      StPressDb: begin
        if (!key_low) begin
          st_d  = StIdle;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d  = StDown;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDown: begin
        if (!key_low) begin
          st_d  = StReleaseDb;
          cnt_d = '0;
        end
      end
      StReleaseDb: begin
        if (key_low) begin
          st_d  = StDown;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d  = StIdle;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output next values: pulses on debounce completion, level follows the FSM
  always_comb begin
    press_d   = (st_q == StPressDb) && key_low && (cnt_q == CNT_MAX);
    release_d = (st_q == StReleaseDb) && !key_low && (cnt_q == CNT_MAX);
    state_d   = (st_d == StDown) || (st_d == StReleaseDb);
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_LONG_PRESS_EN
  logic [LongW-1:0] long_cnt_q, long_cnt_d;
  logic             long_done_q, long_done_d;
  logic             long_q, long_d;

  // Long-press counter and one-shot flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  // Count only while DOWN (held in RELEASE_DB), saturate, fire once per press
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (st_q == StDown) begin
      if (long_cnt_q != LONG_MAX) begin
        long_cnt_d = long_cnt_q + 1'b1;
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end
    if (release_d) begin
      long_cnt_d  = '0;
      long_done_d = 1'b0;
    end
  end

  assign long_o = long_q;
`else
  logic unused_long_max;
  assign unused_long_max = ^LONG_MAX;
  assign long_o          = 1'b0;
`endif

endmodule

// File: rtl/key_scan.sv
// Four-key scanner: one independent key_filter per active-low push-button.
// Define KEY_LONG_PRESS_EN to build in long-press detection (key_long).
module key_scan
  import key_scan_pkg::*;
#(
  parameter logic [CntW-1:0]  CNT_MAX  = CntMaxDefault,
  parameter logic [LongW-1:0] LONG_MAX = LongMaxDefault
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [KeyNum-1:0] key_in,
  output logic [KeyNum-1:0] key_state,
  output logic [KeyNum-1:0] key_press,
  output logic [KeyNum-1:0] key_release,
  output logic [KeyNum-1:0] key_long
);

  for (genvar i = 0; i < KeyNum; i++) begin : g_key
    key_filter #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_key_filter (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_n_i   (key_in[i]),
      .state_o   (key_state[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i]),
      .long_o    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with CNT_MAX=4, LONG_MAX=20.
module tb_key_scan;

`ifdef KEY_LONG_PRESS_EN
  localparam int LongOn = 1;
`else
  localparam int LongOn = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_in = 4'hf;
  logic [3:0] key_state, key_press, key_release, key_long;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  key_scan #(
    .CNT_MAX  (20'd4),
    .LONG_MAX (26'd20)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse monitor: counts and last-seen cycle per key
  int press_n[4]  = '{default: 0};
  int rel_n[4]    = '{default: 0};
  int long_n[4]   = '{default: 0};
  int press_cyc[4] = '{default: 0};
  int rel_cyc[4]  = '{default: 0};
  int long_cyc[4] = '{default: 0};
  int all_press_n = 0;
  int all_rel_n   = 0;
  int overlap_n   = 0;
  int drop2_n     = 0;
  logic prev2     = 1'b0;

  always @(negedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[i])   begin press_n[i]++; press_cyc[i] = cyc; end
      if (key_release[i]) begin rel_n[i]++;   rel_cyc[i]   = cyc; end
      if (key_long[i])    begin long_n[i]++;  long_cyc[i]  = cyc; end
    end
    if (key_press == 4'hf)   all_press_n++;
    if (key_release == 4'hf) all_rel_n++;
    if ((key_press & key_release) != 4'h0) overlap_n++;
    if (prev2 && !key_state[2]) drop2_n++;
    prev2 = key_state[2];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    tick(3);
    vec++; if (key_state !== 4'h0) begin err++;
      $display("FAIL reset_state got=%b exp=0000", key_state); end
    vec++; if (key_press !== 4'h0) begin err++;
      $display("FAIL reset_press got=%b exp=0000", key_press); end
    vec++; if (key_release !== 4'h0) begin err++;
      $display("FAIL reset_release got=%b exp=0000", key_release); end
    vec++; if (key_long !== 4'h0) begin err++;
      $display("FAIL reset_long got=%b exp=0000", key_long); end
    sys_rst_n = 1'b1;
    tick(10);
    vec++; if (key_state !== 4'h0 || press_n[0] + press_n[1] + press_n[2] + press_n[3] != 0)
    begin err++;
      $display("FAIL post_reset_idle state=%b presses=%0d exp state=0000 presses=0",
               key_state, press_n[0] + press_n[1] + press_n[2] + press_n[3]); end
  endtask

  task automatic test_long_hold();
    int c0, c1, p0, l0, r0, po;
    c0 = cyc; p0 = press_n[0]; l0 = long_n[0]; r0 = rel_n[0];
    po = press_n[1] + press_n[2] + press_n[3];
    key_in[0] = 1'b0;
    tick(40);
    vec++; if (press_n[0] - p0 != 1) begin err++;
      $display("FAIL hold_press_count got=%0d exp=1", press_n[0] - p0); end
    vec++; if (press_cyc[0] - c0 != 8) begin err++;
      $display("FAIL hold_press_latency got=%0d exp=8", press_cyc[0] - c0); end
    vec++; if (key_state !== 4'b0001) begin err++;
      $display("FAIL hold_state got=%b exp=0001", key_state); end
    vec++; if (long_n[0] - l0 != LongOn) begin err++;
      $display("FAIL hold_long_count got=%0d exp=%0d", long_n[0] - l0, LongOn); end
`ifdef KEY_LONG_PRESS_EN
    vec++; if (long_cyc[0] - press_cyc[0] != 21) begin err++;
      $display("FAIL hold_long_delay got=%0d exp=21", long_cyc[0] - press_cyc[0]); end
`endif
    vec++; if (press_n[1] + press_n[2] + press_n[3] - po != 0 || rel_n[0] != r0) begin err++;
      $display("FAIL hold_no_other got=%0d exp=0",
               press_n[1] + press_n[2] + press_n[3] - po + rel_n[0] - r0); end
    c1 = cyc;
    key_in[0] = 1'b1;
    tick(12);
    vec++; if (rel_n[0] - r0 != 1) begin err++;
      $display("FAIL hold_release_count got=%0d exp=1", rel_n[0] - r0); end
    vec++; if (rel_cyc[0] - c1 != 8) begin err++;
      $display("FAIL hold_release_latency got=%0d exp=8", rel_cyc[0] - c1); end
    vec++; if (key_state !== 4'b0000) begin err++;
      $display("FAIL hold_state_after got=%b exp=0000", key_state); end
  endtask

  task automatic test_bounce();
    int p0, r0;
    p0 = press_n[1]; r0 = rel_n[1];
    for (int b = 0; b < 4; b++) begin
      key_in[1] = 1'b0;
      tick(3);
      key_in[1] = 1'b1;
      tick(2);
      vec++; if (key_state[1] !== 1'b0) begin err++;
        $display("FAIL bounce_state burst=%0d got=%b exp=0", b, key_state[1]); end
    end
    tick(10);
    vec++; if (press_n[1] - p0 != 0 || rel_n[1] - r0 != 0) begin err++;
      $display("FAIL bounce_pulses press=%0d release=%0d exp=0,0",
               press_n[1] - p0, rel_n[1] - r0); end
  endtask

  task automatic test_glitch();
    int p0, r0, d0, c1;
    p0 = press_n[2]; r0 = rel_n[2]; d0 = drop2_n;
    key_in[2] = 1'b0;
    tick(10);
    key_in[2] = 1'b1;
    tick(2);
    key_in[2] = 1'b0;
    tick(10);
    vec++; if (key_state[2] !== 1'b1 || drop2_n != d0) begin err++;
      $display("FAIL glitch_state got=%b drops=%0d exp=1 drops=0", key_state[2], drop2_n - d0);
    end
    c1 = cyc;
    key_in[2] = 1'b1;
    tick(12);
    vec++; if (press_n[2] - p0 != 1) begin err++;
      $display("FAIL glitch_press_count got=%0d exp=1", press_n[2] - p0); end
    vec++; if (rel_n[2] - r0 != 1) begin err++;
      $display("FAIL glitch_release_count got=%0d exp=1", rel_n[2] - r0); end
    vec++; if (rel_cyc[2] - c1 != 8) begin err++;
      $display("FAIL glitch_release_latency got=%0d exp=8", rel_cyc[2] - c1); end
  endtask

  task automatic test_simultaneous();
    int ap, ar;
    ap = all_press_n; ar = all_rel_n;
    key_in = 4'h0;
    tick(15);
    vec++; if (all_press_n - ap != 1) begin err++;
      $display("FAIL simul_press got=%0d exp=1", all_press_n - ap); end
    vec++; if (key_state !== 4'hf) begin err++;
      $display("FAIL simul_state got=%b exp=1111", key_state); end
    key_in = 4'hf;
    tick(12);
    vec++; if (all_rel_n - ar != 1) begin err++;
      $display("FAIL simul_release got=%0d exp=1", all_rel_n - ar); end
    vec++; if (key_state !== 4'h0) begin err++;
      $display("FAIL simul_state_after got=%b exp=0000", key_state); end
  endtask

  task automatic test_reset_mid();
    int p0, cr;
    p0 = press_n[0];
    key_in[0] = 1'b0;
    tick(5);
    sys_rst_n = 1'b0;
    tick(1);
    vec++; if ((key_state | key_press | key_release | key_long) !== 4'h0) begin err++;
      $display("FAIL midreset_outputs got=%b exp=0000",
               key_state | key_press | key_release | key_long); end
    tick(2);
    vec++; if (press_n[0] != p0 || key_state !== 4'h0) begin err++;
      $display("FAIL midreset_no_pulse presses=%0d state=%b exp=0 0000",
               press_n[0] - p0, key_state); end
    cr = cyc;
    sys_rst_n = 1'b1;
    tick(12);
    vec++; if (press_n[0] - p0 != 1) begin err++;
      $display("FAIL midreset_press_count got=%0d exp=1", press_n[0] - p0); end
    vec++; if (press_cyc[0] - cr != 8) begin err++;
      $display("FAIL midreset_press_latency got=%0d exp=8", press_cyc[0] - cr); end
    key_in[0] = 1'b1;
    tick(12);
  endtask

  task automatic test_no_long();
    int l0, p0, r0;
    l0 = long_n[3]; p0 = press_n[3]; r0 = rel_n[3];
    key_in[3] = 1'b0;
    tick(100);
    vec++; if (long_n[3] - l0 != LongOn) begin err++;
      $display("FAIL long_cfg got=%0d exp=%0d", long_n[3] - l0, LongOn); end
    vec++; if (press_n[3] - p0 != 1) begin err++;
      $display("FAIL long_cfg_press got=%0d exp=1", press_n[3] - p0); end
    key_in[3] = 1'b1;
    tick(12);
    vec++; if (rel_n[3] - r0 != 1) begin err++;
      $display("FAIL long_cfg_release got=%0d exp=1", rel_n[3] - r0); end
  endtask

  initial begin
    test_reset();
    test_long_hold();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_no_long();
    vec++; if (overlap_n != 0) begin err++;
      $display("FAIL press_release_overlap got=%0d exp=0", overlap_n); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
